fractal_sync_tx_arb: RTL

- Round-robin arbiter that drains N_CH fractal-sync tx response FIFOs onto one outgoing response channel with a valid/ready handshake.
- Typical sources are the en/ws FIFOs of one or more tx datapaths.
- Sits between the tx datapaths and the upstream/downstream link.
- Supports bounded bursts per channel, so a channel may keep the grant for up to MAX_BURST consecutive responses before forced rotation.

---
 rtl/fractal_sync_tx_arb.sv | 117 +++++++++++
 1 files changed

// File: rtl/fractal_sync_tx_arb.sv
// Round-robin arbiter draining N_CH fall-through response FIFOs onto one
// registered valid/ready response channel, with bounded per-channel bursts.
module fractal_sync_tx_arb #(
  parameter type fsync_rsp_t = logic,
  parameter int  N_CH        = 2,
  parameter int  MAX_BURST   = 1,
  localparam int GNT_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  empty_i,
  input  fsync_rsp_t       rsp_i [N_CH],
  output logic [N_CH-1:0]  pop_o,
  output fsync_rsp_t       rsp_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [GNT_W-1:0] grant_o,
  output logic             busy_o
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  state_e           state_q;
  fsync_rsp_t       rsp_q;
  logic [GNT_W-1:0] grant_q;
  logic [GNT_W-1:0] rr_q;
  logic [GNT_W-1:0] owner_q;
  logic [CNT_W-1:0] burst_q;

  logic             load;
  logic             any_req;
  logic             grant;
  logic             sticky;
  logic             scan_hit;
  logic [GNT_W-1:0] scan_sel;
  logic [GNT_W-1:0] sel;
  logic [GNT_W-1:0] rr_d;
  logic [GNT_W-1:0] idx;
  int               j;

  // First non-empty channel at or after the rr pointer, wrapping.
  always_comb begin
    scan_sel = rr_q;
    scan_hit = 1'b0;
    idx      = '0;
    j        = 0;
    for (int i = 0; i < N_CH; i++) begin
      j = int'(rr_q) + i;
      if (j >= N_CH) j = j - N_CH;
      idx = GNT_W'(j);
      if (!scan_hit && !empty_i[idx]) begin
        scan_sel = idx;
        scan_hit = 1'b1;
      end
    end
  end

  always_comb begin
    any_req = |(~empty_i);
    load    = (state_q == ST_EMPTY) || ready_i;
    grant   = load && any_req && !rst_i;
    sticky  = (MAX_BURST > 1) && !empty_i[owner_q]
              && (int'(burst_q) < MAX_BURST - 1);
    sel     = sticky ? owner_q : scan_sel;
    rr_d    = (scan_sel == GNT_W'(N_CH - 1)) ? '0
                                            : scan_sel + 1'b1;
    pop_o   = '0;
    if (grant) pop_o[sel] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      rsp_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      owner_q <= '0;
      burst_q <= '0;
    end else if (grant) begin
      state_q <= ST_FULL;
      rsp_q   <= rsp_i[sel];
      grant_q <= sel;
      owner_q <= sel;
      if (sticky) begin
        burst_q <= burst_q + 1'b1;
      end else begin
        // A scan grant always opens a fresh burst, even for the same owner.
        burst_q <= '0;
        rr_q    <= rr_d;
      end
    end else if (state_q == ST_FULL && ready_i) begin
      state_q <= ST_EMPTY;
    end
  end

  assign rsp_o   = rsp_q;
  assign valid_o = (state_q == ST_FULL);
  assign grant_o = grant_q;
  assign busy_o  = valid_o || any_req;

`ifndef SYNTHESIS
  a_par: assert property (@(posedge clk_i)
    (N_CH >= 1) && (MAX_BURST >= 1));
  a_oh: assert property (@(posedge clk_i)
    $onehot0(pop_o));
  a_pe: assert property (@(posedge clk_i)
    (pop_o & empty_i) == '0);
  a_st: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> $stable(rsp_o));
`endif

endmodule
